sum_bcd_display: RTL

Downstream display stage for the switch-controlled accumulator. It consumes the accumulator's 10-bit running sum and converts it to decimal with an iterative, one-bit-per-cycle double-dabble engine. It drives four active-low 7-segment displays (HEX3..HEX0), with optional leading-zero blanking. Conversion restarts automatically whenever the input value changes, so the displays always settle to the latest sum.

---
 rtl/sum_bcd_pkg.sv | 49 ++++
 rtl/sum_bcd_display_seg7_decoder.sv | 38 +++
 rtl/sum_bcd_display.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sum_bcd_pkg.sv
// -----------------------------------------------------------------------------
// sum_bcd_pkg
// Shared types, segment codes and helpers for the BCD display stage.
//   state_t    : conversion FSM states (IDLE, SHIFT, DONE)
//   SEG_*      : active-low 7-segment codes, bit0 = a .. bit6 = g
//   add3()     : double-dabble nibble correction (+3 when nibble >= 5)
//   pow10()    : elaboration-time power of ten used for the range check
// -----------------------------------------------------------------------------
package sum_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   // A nibble that would overflow past 9 after the next shift is pre-corrected.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned acc;
      acc = 64'd1;
      for (int i = 0; i < n; i++) begin
         acc = acc * 64'd10;
      end
      return acc;
   endfunction

endpackage

// File: rtl/sum_bcd_display_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD digit to active-low 7-segment encoder.
//   digit : 4-bit BCD digit (10..15 decode to blank)
//   blank : force all segments off
//   seg   : active-low segments, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module seg7_decoder
   import sum_bcd_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   // Digit lookup; blanking and out-of-range codes both give all segments off.
   always_comb begin
      seg = SEG_BLANK;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/sum_bcd_display.sv
// -----------------------------------------------------------------------------
// sum_bcd_display
// Converts the accumulator's binary running sum to decimal with an iterative
// double-dabble engine (one bit per cycle) and drives four active-low
// 7-segment displays. A new conversion starts whenever value differs from the
// last converted value; displays hold their old digits until it completes.
//   CLOCK      : system clock, rising edge
//   RESETn     : asynchronous active-low reset
//   value      : binary sum, may change any cycle
//   HEX0..HEX3 : ones..thousands digit, active-low segments
//   busy       : conversion in progress
//   valid      : HEX outputs represent the last converted value
// -----------------------------------------------------------------------------
module sum_bcd_display
   import sum_bcd_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned DIGITS   = 4,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic             CLOCK,
   input  logic             RESETn,
   input  logic [WIDTH-1:0] value,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX3,
   output logic             busy,
   output logic             valid
);

   localparam int unsigned SR_W  = 4 * DIGITS + WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

   // The largest binary input must fit in the available decimal digits.
   if (MAX_BIN >= pow10(DIGITS)) begin : g_range_err
      $error("sum_bcd_display: 2**WIDTH-1 does not fit in DIGITS decimal digits");
   end

   state_t              state_r;
   state_t              state_nxt_s;
   logic [WIDTH-1:0]    last_value_r;
   logic [SR_W-1:0]     sr_r;          // {bcd, bin}
   logic [SR_W-1:0]     sr_adj_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                busy_r;
   logic                valid_r;
   logic [6:0]          hex_r     [DIGITS];
   logic [6:0]          seg_s     [DIGITS];
   logic [3:0]          digit_s   [DIGITS];
   logic [DIGITS-1:0]   blank_s;
   logic                hz_s;
   logic                load_s;
   logic                shift_s;
   logic                done_s;
   logic [6:0]          hex_out_s [4];

   // State register.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (value != last_value_r) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_W'(1)) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state.
   always_comb begin
      load_s  = 1'b0;
      shift_s = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE:    load_s  = (value != last_value_r);
         SHIFT:   shift_s = 1'b1;
         DONE:    done_s  = 1'b1;
         default: load_s  = 1'b0;
      endcase
   end

   // Parallel +3 correction of every BCD nibble ahead of the shift.
   always_comb begin
      sr_adj_s = sr_r;
      for (int d = 0; d < int'(DIGITS); d++) begin
         sr_adj_s[WIDTH + 4*d +: 4] = add3(sr_r[WIDTH + 4*d +: 4]);
      end
   end

   // Leading-zero blanking: a digit blanks when it and every higher digit are
   // zero. The ones digit is never blanked.
   always_comb begin
      blank_s = '0;
      hz_s    = 1'b1;
      for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
         if (sr_r[WIDTH + 4*d +: 4] != 4'd0) begin
            hz_s = 1'b0;
         end else begin
            hz_s = hz_s;
         end
         blank_s[d] = BLANK_LZ & hz_s;
      end
   end

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
      assign digit_s[g] = sr_r[WIDTH + 4*g +: 4];
      seg7_decoder u_dec (
         .digit (digit_s[g]),
         .blank (blank_s[g]),
         .seg   (seg_s[g])
      );
   end

   // Conversion datapath and registered display outputs.
   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         last_value_r <= '0;
         sr_r         <= '0;
         cnt_r        <= '0;
         busy_r       <= 1'b0;
         valid_r      <= 1'b1;
         for (int d = 0; d < int'(DIGITS); d++) begin
            hex_r[d] <= ((d == 0) || !BLANK_LZ) ? SEG_0 : SEG_BLANK;
         end
      end else begin
         if (load_s) begin
            sr_r         <= {{(4*DIGITS){1'b0}}, value};
            last_value_r <= value;
            cnt_r        <= CNT_W'(WIDTH);
            busy_r       <= 1'b1;
            valid_r      <= 1'b0;
         end else if (shift_s) begin
            sr_r  <= {sr_adj_s[SR_W-2:0], 1'b0};
            cnt_r <= cnt_r - CNT_W'(1);
         end else if (done_s) begin
            for (int d = 0; d < int'(DIGITS); d++) begin
               hex_r[d] <= seg_s[d];
            end
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
         end else begin
            busy_r <= busy_r;
         end
      end
   end

   // Map the digit registers onto the four physical displays.
   for (genvar k = 0; k < 4; k++) begin : g_out
      if (k < int'(DIGITS)) begin : g_used
         assign hex_out_s[k] = hex_r[k];
      end else begin : g_unused
         assign hex_out_s[k] = SEG_BLANK;
      end
   end

   assign HEX0  = hex_out_s[0];
   assign HEX1  = hex_out_s[1];
   assign HEX2  = hex_out_s[2];
   assign HEX3  = hex_out_s[3];
   assign busy  = busy_r;
   assign valid = valid_r;

endmodule
